// File: rtl/joy_serial_reader_if.sv
// Signal bundle between the joystick reader, the external 74HC165 chain and the consuming core.
// master = reader side, slave = chain/core side.
interface joy_serial_reader_if;
  logic        joy_data_i;
  logic        joy_clk_o;
  logic        joy_load_o;
  logic [11:0] joy1_o;
  logic [11:0] joy2_o;
  logic        frame_strobe_o;

  modport master (
    input  joy_data_i,
    output joy_clk_o, joy_load_o, joy1_o, joy2_o, frame_strobe_o
  );

  modport slave (
    output joy_data_i,
    input  joy_clk_o, joy_load_o, joy1_o, joy2_o, frame_strobe_o
  );
endinterface

// File: rtl/joy_serial_reader.sv
// Scans two DB9 joysticks through a 74HC165 chain and presents double-buffered active-low 12-bit vectors.
// Optional macro JOY_FILTER_EN: commit a frame only when it repeats the previous frame for both players.
module joy_serial_reader #(
  parameter int unsigned CLK_HALF  = 16,
  parameter int unsigned FRAME_LEN = 26
) (
  input  logic                clk_i,
  input  logic                res_n_i,
  joy_serial_reader_if.master bus
);
  localparam int unsigned   DW        = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_HALF - 1);
  localparam logic [4:0]    SLOT_LAST = 5'(FRAME_LEN - 1);

  logic [DW-1:0] div_q, div_d;
  logic          jclk_q, jclk_d;
  logic          sync1_q, sync2_q;
  logic [4:0]    slot_q, slot_d;
  logic          load_q, load_d;
  logic [11:0]   sh1_q, sh1_d, sh2_q, sh2_d;
  logic [11:0]   j1_q, j1_d, j2_q, j2_d;
  logic          strobe_q, strobe_d;
  logic          wrap, tick;
  logic [4:0]    map;
`ifdef JOY_FILTER_EN
  logic [11:0]   prev1_q, prev1_d, prev2_q, prev2_d;
`endif

  // {capture, bit index}; slots 0 and 1 carry no joystick data (load + chain pipeline)
  function automatic logic [4:0] slot_bit(input logic [4:0] s);
    case (s)
      5'd2,  5'd10: slot_bit = {1'b1, 4'd8};
      5'd3,  5'd11: slot_bit = {1'b1, 4'd6};
      5'd4,  5'd12: slot_bit = {1'b1, 4'd5};
      5'd5,  5'd13: slot_bit = {1'b1, 4'd4};
      5'd6,  5'd14: slot_bit = {1'b1, 4'd3};
      5'd7,  5'd15: slot_bit = {1'b1, 4'd2};
      5'd8,  5'd16: slot_bit = {1'b1, 4'd1};
      5'd9,  5'd17: slot_bit = {1'b1, 4'd0};
      5'd18, 5'd22: slot_bit = {1'b1, 4'd10};
      5'd19, 5'd23: slot_bit = {1'b1, 4'd11};
      5'd20, 5'd24: slot_bit = {1'b1, 4'd9};
      5'd21, 5'd25: slot_bit = {1'b1, 4'd7};
      default:      slot_bit = '0;
    endcase
  endfunction

  always_comb begin
    wrap     = (div_q == DIV_LAST);
    tick     = wrap && !jclk_q;
    div_d    = wrap ? '0 : div_q + 1'b1;
    jclk_d   = wrap ? ~jclk_q : jclk_q;
    slot_d   = slot_q;
    load_d   = load_q;
    sh1_d    = sh1_q;
    sh2_d    = sh2_q;
    j1_d     = j1_q;
    j2_d     = j2_q;
    strobe_d = 1'b0;
    map      = slot_bit(slot_q);
`ifdef JOY_FILTER_EN
    prev1_d  = prev1_q;
    prev2_d  = prev2_q;
`endif
    if (tick) begin
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 5'd1;
      load_d = (slot_d != '0);
      if (map[4]) begin
        if (slot_q >= 5'd10 && slot_q <= 5'd21) sh2_d[map[3:0]] = sync2_q;
        else                                    sh1_d[map[3:0]] = sync2_q;
      end
      // commit uses the _d shadows so the bit sampled on the final tick is included
      if (slot_q == SLOT_LAST) begin
        strobe_d = 1'b1;
`ifdef JOY_FILTER_EN
        if (sh1_d == prev1_q && sh2_d == prev2_q) begin
          j1_d = sh1_d;
          j2_d = sh2_d;
        end
        prev1_d = sh1_d;
        prev2_d = sh2_d;
`else
        j1_d = sh1_d;
        j2_d = sh2_d;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      div_q    <= '0;
      jclk_q   <= 1'b0;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      slot_q   <= '0;
      load_q   <= 1'b0;
      sh1_q    <= '1;
      sh2_q    <= '1;
      j1_q     <= '1;
      j2_q     <= '1;
      strobe_q <= 1'b0;
`ifdef JOY_FILTER_EN
      prev1_q  <= '1;
      prev2_q  <= '1;
`endif
    end else begin
      div_q    <= div_d;
      jclk_q   <= jclk_d;
      sync1_q  <= bus.joy_data_i;
      sync2_q  <= sync1_q;
      slot_q   <= slot_d;
      load_q   <= load_d;
      sh1_q    <= sh1_d;
      sh2_q    <= sh2_d;
      j1_q     <= j1_d;
      j2_q     <= j2_d;
      strobe_q <= strobe_d;
`ifdef JOY_FILTER_EN
      prev1_q  <= prev1_d;
      prev2_q  <= prev2_d;
`endif
    end
  end

  assign bus.joy_clk_o      = jclk_q;
  assign bus.joy_load_o     = load_q;
  assign bus.joy1_o         = j1_q;
  assign bus.joy2_o         = j2_q;
  assign bus.frame_strobe_o = strobe_q;
endmodule
